// File: rtl/decim_share_sched_if.sv
// -----------------------------------------------------------------------------
// decim_share_sched_if
//   Bundle of the request side (per-channel req / data / shift count / grant)
//   and the result side (data_out / out_ch / out_valid / out_ready / busy) of
//   the shared decimation scheduler.
//
//   Modports:
//     master : drives req, data_in, shift_amt, out_ready (channels + downstream)
//     slave  : drives grant, data_out, out_ch, out_valid, busy (the scheduler)
//
//   Parameters must match those of the decim_share_sched instance it connects.
// -----------------------------------------------------------------------------
interface decim_share_sched_if #(
  parameter int WORD_LENGTH = 8,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int SHIFT_W     = 3
) ();

  logic [N_CH-1:0]             req;
  logic [N_CH*WORD_LENGTH-1:0] data_in;
  logic [N_CH*SHIFT_W-1:0]     shift_amt;
  logic [N_CH-1:0]             grant;
  logic [WORD_LENGTH-1:0]      data_out;
  logic [CH_W-1:0]             out_ch;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  modport master (
    output req, data_in, shift_amt, out_ready,
    input  grant, data_out, out_ch, out_valid, busy
  );

  modport slave (
    input  req, data_in, shift_amt, out_ready,
    output grant, data_out, out_ch, out_valid, busy
  );

endinterface

// File: rtl/decim_share_sched.sv
// -----------------------------------------------------------------------------
// decim_share_sched
//   Time-shares one logical shift-right decimation datapath among N_CH
//   channels. In IDLE the scheduler picks one requesting channel, loads its
//   word and shift count, pulses that channel's grant for one cycle, shifts
//   right by one bit per cycle for the requested count, then holds the result
//   with out_valid until out_ready is seen.
//
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high reset (discards any transaction)
//     bus   : decim_share_sched_if.slave
//               req/data_in/shift_amt in, grant out   (channel side)
//               data_out/out_ch/out_valid out, out_ready in, busy out
//
//   Configuration macro:
//     DECIM_SHARE_SCHED_RR_EN
//       defined   : round-robin arbitration, search starts at pointer+1
//       undefined : fixed priority, lowest channel index wins
//
//   Throughput is one transaction per (shift + 2) cycles at best: the
//   OUTPUT -> IDLE return always costs one cycle before the next load.
// -----------------------------------------------------------------------------
module decim_share_sched #(
  parameter int WORD_LENGTH = 8,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int SHIFT_W     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  decim_share_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WORD_LENGTH-1:0] r_data;
  logic [SHIFT_W-1:0]     r_cnt;
  logic [CH_W-1:0]        r_out_ch;
  logic [N_CH-1:0]        r_grant;
  logic                   r_out_valid;
  logic                   r_busy;

  logic                   w_any_req;
  logic [CH_W-1:0]        w_win;
  logic [WORD_LENGTH-1:0] w_win_data;
  logic [SHIFT_W-1:0]     w_win_shift;

`ifdef DECIM_SHARE_SCHED_RR_EN
  // Last granted channel; resets to N_CH-1 so channel 0 is searched first.
  // Only the round-robin search reads it, so the fixed-priority build has
  // no pointer register at all.
  logic [CH_W-1:0]        r_ptr;
  logic [CH_W-1:0]        w_idx;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration. Loops run from the lowest to the highest search priority so
  // that the last assignment made is the winner.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    w_any_req = |bus.req;
    w_win     = '0;
`ifdef DECIM_SHARE_SCHED_RR_EN
    w_idx     = '0;
    // Offset N_CH-1 from pointer+1 is the least preferred, offset 0 the most.
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = CH_W'((int'(r_ptr) + 1 + i) % N_CH);
      if (bus.req[w_idx]) w_win = w_idx;
    end
`else
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (bus.req[c]) w_win = CH_W'(c);
    end
`endif
  end

  // Word and shift count of the winning channel.
  always_comb begin
    w_win_data  = '0;
    w_win_shift = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_win == CH_W'(c)) begin
        w_win_data  = bus.data_in[c*WORD_LENGTH +: WORD_LENGTH];
        w_win_shift = bus.shift_amt[c*SHIFT_W +: SHIFT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_out_ch    <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DECIM_SHARE_SCHED_RR_EN
      r_ptr       <= CH_W'(N_CH - 1);
`endif
    end else begin
      // Grant is a single-cycle pulse on the load edge only.
      r_grant <= '0;

      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_data   <= w_win_data;
            r_cnt    <= w_win_shift;
            r_out_ch <= w_win;
            r_grant  <= N_CH'(1) << w_win;
            r_busy   <= 1'b1;
`ifdef DECIM_SHARE_SCHED_RR_EN
            r_ptr    <= w_win;
`endif
            if (w_win_shift != '0) begin
              r_state <= SHIFT;
            end else begin
              r_state     <= OUTPUT;
              r_out_valid <= 1'b1;
            end
          end
        end

        SHIFT: begin
          // Logical shift: zero fill, so shifting past the word width gives 0.
          r_data <= r_data >> 1;
          r_cnt  <= r_cnt - SHIFT_W'(1);
          if (r_cnt == SHIFT_W'(1)) begin
            r_state     <= OUTPUT;
            r_out_valid <= 1'b1;
          end
        end

        OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.data_out  = r_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule
